// File: rtl/regwrite_arbiter.sv
// rtl/regwrite_arbiter.sv - round-robin arbiter draining ALU/load write FIFOs onto the register file write port
module regwrite_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_reg,
    input  logic [63:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_reg,
    input  logic [63:0] mem_data,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [63:0] WriteData,
    output logic [31:0] pending
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Source index 0 is the ALU, 1 is the load path.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    logic [4:0]    q_reg  [2][DEPTH];
    logic [63:0]   q_data [2][DEPTH];
    logic [PW-1:0] wptr   [2];
    logic [PW-1:0] rptr   [2];
    logic [CW-1:0] cnt    [2];

    logic [4:0]    in_reg  [2];
    logic [63:0]   in_data [2];
    logic [1:0]    in_valid;
    logic [1:0]    rdy;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    nonempty;

    src_e          last_grant;
    src_e          grant_src;
    logic          grant_any;
    logic [4:0]    head_reg;
    logic [63:0]   head_data;
    logic [PW-1:0] off;

    assign alu_ready = rdy[0];
    assign mem_ready = rdy[1];

    // Handshake qualification and round-robin choice between the two FIFO heads.
    always_comb begin
        in_valid   = {mem_valid, alu_valid};
        in_reg[0]  = alu_reg;
        in_reg[1]  = mem_reg;
        in_data[0] = alu_data;
        in_data[1] = mem_data;
        rdy        = '0;
        push       = '0;
        nonempty   = '0;
        for (int s = 0; s < 2; s++) begin
            // Ready looks only at the registered count, so a same-cycle pop never opens a slot.
            rdy[s]      = !reset && (cnt[s] < FULL);
            // X31 writes complete the handshake but are dropped here.
            push[s]     = in_valid[s] && rdy[s] && (in_reg[s] != 5'd31);
            nonempty[s] = (cnt[s] != '0);
        end
        grant_any = |nonempty;
        grant_src = SRC_ALU;
        if (nonempty[0] && nonempty[1]) begin
            grant_src = (last_grant == SRC_MEM) ? SRC_ALU : SRC_MEM;
        end else if (nonempty[1]) begin
            grant_src = SRC_MEM;
        end
        pop       = '0;
        pop[0]    = grant_any && (grant_src == SRC_ALU);
        pop[1]    = grant_any && (grant_src == SRC_MEM);
        head_reg  = q_reg[grant_src][rptr[grant_src]];
        head_data = q_data[grant_src][rptr[grant_src]];
    end

    // FIFO storage/pointers, grant history and the write-port output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                wptr[s] <= '0;
                rptr[s] <= '0;
                cnt[s]  <= '0;
            end
            last_grant    <= SRC_MEM;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) begin
                    q_reg[s][wptr[s]]  <= in_reg[s];
                    q_data[s][wptr[s]] <= in_data[s];
                    wptr[s]            <= wptr[s] + PW'(1);
                end
                if (pop[s]) begin
                    rptr[s] <= rptr[s] + PW'(1);
                end
                if (push[s] && !pop[s]) begin
                    cnt[s] <= cnt[s] + CW'(1);
                end else if (!push[s] && pop[s]) begin
                    cnt[s] <= cnt[s] - CW'(1);
                end
            end
            RegWrite <= grant_any;
            if (grant_any) begin
                WriteRegister <= head_reg;
                WriteData     <= head_data;
                last_grant    <= grant_src;
            end
        end
    end

    // Pending bitmap: every occupied FIFO slot plus the write currently on the port.
    always_comb begin
        pending = '0;
        off     = '0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                off = PW'(i) - rptr[s];
                if ({1'b0, off} < cnt[s]) begin
                    pending[q_reg[s][i]] = 1'b1;
                end
            end
        end
        if (RegWrite) begin
            pending[WriteRegister] = 1'b1;
        end
        pending[31] = 1'b0;
    end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb/tb_regwrite_arbiter.sv - randomized scoreboard bench for regwrite_arbiter
module tb_regwrite_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_reg = '0;
    logic [63:0] alu_data = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [4:0]  mem_reg = '0;
    logic [63:0] mem_data = '0;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [31:0] pending;

    regwrite_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  r;
        logic [63:0] d;
    } wr_t;

    wr_t        aq[$];
    wr_t        mq[$];
    wr_t        expw[$];
    int         expc[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic       out_v = 1'b0;
    logic [4:0] out_r = '0;
    logic       last_mem = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p;
        p = '0;
        foreach (aq[i]) p[aq[i].r] = 1'b1;
        foreach (mq[i]) p[mq[i].r] = 1'b1;
        if (out_v) p[out_r] = 1'b1;
        p[31] = 1'b0;
        return p;
    endfunction

    // One clock of stimulus: drive, check ready/pending, advance the queue model at the edge.
    task automatic step(input logic rst,
                        input logic av, input logic [4:0] ar, input logic [63:0] ad,
                        input logic mv, input logic [4:0] mr, input logic [63:0] md);
        logic a_ok;
        logic m_ok;
        int   g;
        wr_t  w;
        reset = rst;
        alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md;
        #1;
        a_ok = !rst && (aq.size() < DEPTH);
        m_ok = !rst && (mq.size() < DEPTH);
        chk("alu_ready", 64'(alu_ready), 64'(a_ok));
        chk("mem_ready", 64'(mem_ready), 64'(m_ok));
        chk("pending", 64'(pending), 64'(model_pending()));
        @(posedge clk);
        cyc++;
        if (rst) begin
            aq.delete();
            mq.delete();
            out_v = 1'b0;
            last_mem = 1'b1;
        end else begin
            g = -1;
            if (aq.size() > 0 && mq.size() > 0) g = last_mem ? 0 : 1;
            else if (aq.size() > 0) g = 0;
            else if (mq.size() > 0) g = 1;
            w = '0;
            if (g == 0) begin
                w = aq.pop_front();
                last_mem = 1'b0;
            end else if (g == 1) begin
                w = mq.pop_front();
                last_mem = 1'b1;
            end
            out_v = (g >= 0);
            if (g >= 0) begin
                out_r = w.r;
                expw.push_back(w);
                expc.push_back(cyc);
            end
            if (av && a_ok && ar != 5'd31) aq.push_back({ar, ad});
            if (mv && m_ok && mr != 5'd31) mq.push_back({mr, md});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    // Monitor: every write on the port must match the next scoreboard entry in the predicted cycle.
    initial begin
        wr_t w;
        int  c;
        forever begin
            @(negedge clk);
            if (RegWrite === 1'b1) begin
                if (expw.size() == 0) begin
                    chk("unexpected_write", 64'(RegWrite), 64'd0);
                end else begin
                    w = expw.pop_front();
                    c = expc.pop_front();
                    chk("wr_reg", 64'(WriteRegister), 64'(w.r));
                    chk("wr_data", WriteData, w.d);
                    chk("wr_cycle", 64'(cyc), 64'(c));
                end
            end else if (expw.size() > 0 && expc[0] <= cyc) begin
                chk("missing_write", 64'(RegWrite), 64'd1);
                void'(expw.pop_front());
                void'(expc.pop_front());
            end
        end
    end

    initial begin
        int   dens;
        int   macc;
        int   n;
        logic rst;
        logic av;
        logic mv;
        logic [4:0] ar;
        logic [4:0] mr;

        @(posedge clk);
        @(negedge clk);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        chk("rst_regwrite", 64'(RegWrite), 64'd0);
        chk("rst_wreg", 64'(WriteRegister), 64'd0);
        chk("rst_wdata", WriteData, 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 64'({alu_ready, mem_ready}), 64'd3);

        // Single uncontended write.
        step(1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 5'd0, 64'd0);
        chk("single_pend_n1", 64'(pending), 64'h20);
        idle(1);
        chk("single_we", 64'(RegWrite), 64'd1);
        chk("single_reg", 64'(WriteRegister), 64'd5);
        chk("single_data", WriteData, 64'hDEAD_BEEF);
        chk("single_pend_n2", 64'(pending), 64'h20);
        idle(1);
        chk("single_pend_n3", 64'(pending), 64'h0);

        // First tie after reset goes to the ALU.
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        step(1'b0, 1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22);
        idle(1);
        chk("tie_first", 64'(WriteRegister), 64'd1);
        chk("tie_first_data", WriteData, 64'h11);
        idle(1);
        chk("tie_second", 64'(WriteRegister), 64'd2);
        chk("tie_second_data", WriteData, 64'h22);
        idle(2);

        // Backpressure: both saturated, MEM holds each write until it is accepted.
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        macc = 0;
        n = 0;
        while (macc < 4 && n < 20) begin
            rst = (mq.size() < DEPTH);
            step(1'b0, 1'b1, 5'(10 + (n % 8)), 64'(n), 1'b1, 5'(20 + macc), 64'h100 + 64'(macc));
            if (rst) macc++;
            if (n == 1) chk("bp_mem_full", 64'(mem_ready), 64'd0);
            n++;
        end
        chk("bp_accepts", 64'(macc), 64'd4);
        idle(6);

        // Writes to X31 are accepted and vanish.
        step(1'b0, 1'b1, 5'd31, 64'hFFFF, 1'b0, 5'd0, 64'd0);
        repeat (3) begin
            idle(1);
            chk("zero_no_write", 64'(RegWrite), 64'd0);
            chk("zero_no_pending", 64'(pending), 64'd0);
        end

        // Pending bitmap over queued and in-flight writes.
        step(1'b0, 1'b1, 5'd3, 64'h3, 1'b1, 5'd7, 64'h7);
        step(1'b0, 1'b1, 5'd4, 64'h4, 1'b0, 5'd0, 64'd0);
        chk("pend_98", 64'(pending), 64'h98);
        idle(1);
        chk("pend_90", 64'(pending), 64'h90);
        idle(1);
        chk("pend_10", 64'(pending), 64'h10);
        idle(1);
        chk("pend_00", 64'(pending), 64'h0);

        // Reset mid-operation flushes everything queued.
        repeat (3) step(1'b0, 1'b1, 5'd8, 64'h8, 1'b1, 5'd9, 64'h9);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        chk("midrst_regwrite", 64'(RegWrite), 64'd0);
        chk("midrst_pending", 64'(pending), 64'd0);
        reset = 1'b0;
        #1;
        chk("midrst_ready", 64'({alu_ready, mem_ready}), 64'd3);
        repeat (3) begin
            idle(1);
            chk("midrst_no_stale", 64'(RegWrite), 64'd0);
        end

        // Randomized traffic with varying density and occasional reset.
        dens = 60;
        for (int k = 0; k < 2500; k++) begin
            if (k % 250 == 0) dens = (k / 250 % 3 == 0) ? 100 : ((k / 250 % 3 == 1) ? 25 : 60);
            rst = ($urandom_range(0, 299) == 0);
            av  = ($urandom_range(0, 99) < dens);
            mv  = ($urandom_range(0, 99) < dens);
            ar  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
            mr  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
            step(rst, av, ar, {$urandom(), $urandom()}, mv, mr, {$urandom(), $urandom()});
        end

        idle(8);
        chk("drain_empty", 64'(expw.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
